deparser_head_packer: RTL

//  Egress stage directly downstream of the 3-layer deparser. It consumes the tagged head slices on
//  the deparser's o_head output. The deparser has no backpressure, so slices enter a skid FIFO.

---
 rtl/deparser_head_packer.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/deparser_head_packer.sv
// Egress packer behind the deparser: buffers tagged head slices in a skid FIFO and
// compacts them into left-aligned full-width beats on a valid/ready stream with sop/eop/len.
module deparser_head_packer #(
    parameter int HEAD_W     = 128,
    parameter int TAG_W      = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [HEAD_W+TAG_W-1:0] i_head,
    output logic [HEAD_W-1:0]       o_data,
    output logic [4:0]              o_len,
    output logic                    o_sop,
    output logic                    o_eop,
    output logic                    o_err,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [HEAD_W-1:0] data;
        logic [3:0]        offset;
        logic              tail;
        logic              start;
        logic              abort;
    } entry_t;

    typedef enum logic [1:0] {IDLE, PACK, FLUSH} state_t;

    logic [HEAD_W-1:0] inData;
    logic [TAG_W-1:0]  inTag;
    logic              inValid, inShift, inTail, inStart;
    logic [3:0]        inOffset;

    assign inData   = i_head[HEAD_W+TAG_W-1:TAG_W];
    assign inTag    = i_head[TAG_W-1:0];
    assign inValid  = inTag[7];
    assign inShift  = inTag[6];
    assign inTail   = inTag[5];
    assign inStart  = inTag[4];
    assign inOffset = inTag[3:0];

    entry_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wrPtr_q, rdPtr_q;
    logic [PTR_W:0]     count_q;
    logic               full, empty;
    entry_t             head, wrEntry;
    logic               wrEn, pop;

    logic dropping_q, dropping_d;
    logic abortPend_q, abortPend_d;
    logic overflow_q, overflow_d;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign head  = mem_q[rdPtr_q];

    // A pending abort marker takes the write slot ahead of any incoming slice.
    always_comb begin
        wrEn        = 1'b0;
        wrEntry     = '0;
        dropping_d  = dropping_q;
        abortPend_d = abortPend_q;
        overflow_d  = overflow_q;
        if (abortPend_q && !full) begin
            wrEn          = 1'b1;
            wrEntry.abort = 1'b1;
            abortPend_d   = 1'b0;
            if (inValid && !inShift && inStart) begin
                overflow_d = 1'b1;
            end
        end else if (inValid && !inShift && !(dropping_q && !inStart)) begin
            if (full) begin
                overflow_d = 1'b1;
                if (!inTail) begin
                    dropping_d  = 1'b1;
                    abortPend_d = 1'b1;
                end
            end else begin
                wrEn           = 1'b1;
                wrEntry.data   = inData;
                wrEntry.offset = inOffset;
                wrEntry.tail   = inTail;
                wrEntry.start  = inStart;
                if (inStart) begin
                    dropping_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wrEn) begin
            mem_q[wrPtr_q] <= wrEntry;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            dropping_q  <= 1'b0;
            abortPend_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            dropping_q  <= dropping_d;
            abortPend_q <= abortPend_d;
            overflow_q  <= overflow_d;
            if (wrEn) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            unique case ({wrEn, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    state_t              state_q, state_d;
    logic [HEAD_W-1:0]   resid_q, resid_d;
    logic [3:0]          rLen_q, rLen_d;
    logic                sopPend_q, sopPend_d;

    logic [HEAD_W-1:0]   outData_q;
    logic [4:0]          outLen_q;
    logic                outSop_q, outEop_q, outErr_q, outValid_q;
    logic                canLoad;

    logic [4:0]          nBytes, sum;
    logic [HEAD_W-1:0]   sliceMasked, combHi, combLo;
    logic [2*HEAD_W-1:0] combined;
    logic                sopEff, emit;
    logic [HEAD_W-1:0]   beatData;
    logic [4:0]          beatLen;
    logic                beatSop, beatEop, beatErr;

    assign canLoad = !outValid_q || i_ready;

    // Residue bytes followed by the slice bytes, both left-aligned; unused bytes stay zero.
    assign nBytes      = {1'b0, head.offset} + 5'd1;
    assign sum         = {1'b0, rLen_q} + nBytes;
    assign sliceMasked = head.data & ~({HEAD_W{1'b1}} >> {nBytes, 3'b000});
    assign combined    = {resid_q, {HEAD_W{1'b0}}} | ({sliceMasked, {HEAD_W{1'b0}}} >> {rLen_q, 3'b000});
    assign combHi      = combined[2*HEAD_W-1:HEAD_W];
    assign combLo      = combined[HEAD_W-1:0];
    assign sopEff      = (state_q == IDLE) ? 1'b1 : sopPend_q;

    always_comb begin
        state_d   = state_q;
        resid_d   = resid_q;
        rLen_d    = rLen_q;
        sopPend_d = sopPend_q;
        pop       = 1'b0;
        emit      = 1'b0;
        beatData  = '0;
        beatLen   = '0;
        beatSop   = 1'b0;
        beatEop   = 1'b0;
        beatErr   = 1'b0;
        unique case (state_q)
            FLUSH: begin
                if (canLoad) begin
                    emit      = 1'b1;
                    beatData  = resid_q;
                    beatLen   = {1'b0, rLen_q};
                    beatSop   = sopPend_q;
                    beatEop   = 1'b1;
                    state_d   = IDLE;
                    resid_d   = '0;
                    rLen_d    = '0;
                    sopPend_d = 1'b0;
                end
            end
            IDLE, PACK: begin
                if (canLoad && !empty) begin
                    if (state_q == PACK && (head.abort || head.start)) begin
                        // A new START is left in the FIFO so IDLE picks it up next cycle.
                        pop       = head.abort;
                        emit      = 1'b1;
                        beatData  = resid_q;
                        beatLen   = {1'b0, rLen_q};
                        beatSop   = sopPend_q;
                        beatEop   = 1'b1;
                        beatErr   = 1'b1;
                        state_d   = IDLE;
                        resid_d   = '0;
                        rLen_d    = '0;
                        sopPend_d = 1'b0;
                    end else if (state_q == IDLE && !head.start) begin
                        pop = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        state_d = PACK;
                        beatSop = sopEff;
                        if (head.tail && sum <= 5'd16) begin
                            emit     = 1'b1;
                            beatData = combHi;
                            beatLen  = sum;
                            beatEop  = 1'b1;
                            state_d  = IDLE;
                            resid_d  = '0;
                            rLen_d   = '0;
                        end else if (head.tail || sum[4]) begin
                            emit     = 1'b1;
                            beatData = combHi;
                            beatLen  = 5'd16;
                            resid_d  = combLo;
                            rLen_d   = sum[3:0];
                            state_d  = head.tail ? FLUSH : PACK;
                        end else begin
                            resid_d = combHi;
                            rLen_d  = sum[3:0];
                        end
                        sopPend_d = emit ? 1'b0 : sopEff;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                resid_d = '0;
                rLen_d  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            resid_q   <= '0;
            rLen_q    <= '0;
            sopPend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            resid_q   <= resid_d;
            rLen_q    <= rLen_d;
            sopPend_q <= sopPend_d;
        end
    end

    // Output register holds its beat while stalled; reloads only when empty or transferring.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outLen_q   <= '0;
            outSop_q   <= 1'b0;
            outEop_q   <= 1'b0;
            outErr_q   <= 1'b0;
        end else if (canLoad) begin
            outValid_q <= emit;
            outData_q  <= beatData;
            outLen_q   <= beatLen;
            outSop_q   <= beatSop;
            outEop_q   <= beatEop;
            outErr_q   <= beatErr;
        end
    end

    assign o_data     = outData_q;
    assign o_len      = outLen_q;
    assign o_sop      = outSop_q;
    assign o_eop      = outEop_q;
    assign o_err      = outErr_q;
    assign o_valid    = outValid_q;
    assign o_overflow = overflow_q;

endmodule
